lemming_walker_ctrl: RTL and testbench

Next-generation lemming behaviour controller. It is the successor to the basic walk/fall FSM and adds digging, fall-duration tracking with a splat terminal state, and a parametrised fall threshold and reset direction. One instance controls one lemming. It sits between the level/terrain sensing logic (bump, ground, dig) and the sprite/animation selector, which consumes the one-hot behaviour outputs.

---
 rtl/lemming_pkg.sv | 24 ++
 rtl/lemming_fall_timer.sv | 41 ++++
 rtl/lemming_walker_ctrl.sv | 89 ++++++++
 tb/tb_lemming_walker_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// Shared lemming types: behaviour state encoding, direction constants and
// the fall counter sizing helper used by the controller and its timer.
package lemming_pkg;

  // WALK_L/WALK_R keep fixed codes because other lemming blocks rely on them.
  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } state_e;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  // The counter must reach SPLAT_CYCLES+1 so that "too far" is representable.
  function automatic int cnt_width(input int splat_cycles);
    return $clog2(splat_cycles + 2);
  endfunction

endpackage

// File: rtl/lemming_fall_timer.sv
// Saturating count of consecutive falling cycles; too_far_o flags a fall
// long enough to be fatal on landing.
module lemming_fall_timer
  import lemming_pkg::*;
#(
  parameter int SPLAT_CYCLES = 20
) (
  input  logic clk,
  input  logic areset,
  input  logic inc_i,
  input  logic clr_i,
  output logic too_far_o
);

  localparam int CW = cnt_width(SPLAT_CYCLES);
  localparam logic [CW-1:0] SAT_VAL = CW'(SPLAT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(SPLAT_CYCLES);

  logic [CW-1:0] count_q, count_d;

  // Once past the limit the exact length no longer matters, so hold there.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SAT_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign too_far_o = (count_q > LIMIT);

endmodule

// File: rtl/lemming_walker_ctrl.sv
// Per-lemming behaviour FSM (walk / dig / fall / splat) with one-hot Moore
// outputs for the sprite selector.
module lemming_walker_ctrl
  import lemming_pkg::*;
#(
  parameter int SPLAT_CYCLES    = 20,
  parameter bit RESET_DIR_RIGHT = 1'b0,
  parameter bit DIG_EN          = 1'b1
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic splat
);

  localparam state_e RST_STATE = (RESET_DIR_RIGHT == DIR_R) ? WALK_R : WALK_L;

  state_e state_q, state_d;
  logic   too_far;
  logic   fall_d;

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority from a walking state: losing ground, then digging, then bumps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WALK_L: begin
        if (!ground)                  state_d = FALL_L;
        else if (dig && DIG_EN)       state_d = DIG_L;
        else if (bump_left)           state_d = WALK_R;
      end
      WALK_R: begin
        if (!ground)                  state_d = FALL_R;
        else if (dig && DIG_EN)       state_d = DIG_R;
        else if (bump_right)          state_d = WALK_L;
      end
      DIG_L:  if (!ground) state_d = FALL_L;
      DIG_R:  if (!ground) state_d = FALL_R;
      FALL_L: if (ground)  state_d = too_far ? SPLAT : WALK_L;
      FALL_R: if (ground)  state_d = too_far ? SPLAT : WALK_R;
      SPLAT:               state_d = SPLAT;
      default:             state_d = RST_STATE;
    endcase
  end

  // Counting the entry cycle too makes the count equal the aaah-high cycles.
  assign fall_d = (state_d == FALL_L) || (state_d == FALL_R);

  lemming_fall_timer #(
    .SPLAT_CYCLES(SPLAT_CYCLES)
  ) u_fall_timer (
    .clk      (clk),
    .areset   (areset),
    .inc_i    (fall_d),
    .clr_i    (!fall_d),
    .too_far_o(too_far)
  );

  always_comb begin
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    digging    = 1'b0;
    splat      = 1'b0;
    case (state_q)
      WALK_L:         walk_left  = 1'b1;
      WALK_R:         walk_right = 1'b1;
      FALL_L, FALL_R: aaah       = 1'b1;
      DIG_L, DIG_R:   digging    = DIG_EN;
      SPLAT:          splat      = 1'b1;
      default:        ;
    endcase
  end

endmodule

// File: tb/tb_lemming_walker_ctrl.sv
// Scoreboard bench: each driven cycle queues the expected outputs, which are
// compared one clock later against the default and a variant-parameter DUT.
module tb_lemming_walker_ctrl;

  localparam logic [4:0] O_WL = 5'b10000;
  localparam logic [4:0] O_WR = 5'b01000;
  localparam logic [4:0] O_AA = 5'b00100;
  localparam logic [4:0] O_DG = 5'b00010;
  localparam logic [4:0] O_SP = 5'b00001;

  typedef struct {
    string      tag;
    logic [4:0] exp_a;
    bit         chk_b;
    logic [4:0] exp_b;
  } sb_t;

  logic clk = 1'b0;
  logic areset, bump_left, bump_right, ground, dig;
  logic wl_a, wr_a, aa_a, dg_a, sp_a;
  logic wl_b, wr_b, aa_b, dg_b, sp_b;

  int n_checks = 0;
  int n_errors = 0;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  lemming_walker_ctrl #(
    .SPLAT_CYCLES(20), .RESET_DIR_RIGHT(1'b0), .DIG_EN(1'b1)
  ) dut_a (
    .clk(clk), .areset(areset), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(wl_a), .walk_right(wr_a),
    .aaah(aa_a), .digging(dg_a), .splat(sp_a)
  );

  lemming_walker_ctrl #(
    .SPLAT_CYCLES(20), .RESET_DIR_RIGHT(1'b1), .DIG_EN(1'b0)
  ) dut_b (
    .clk(clk), .areset(areset), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(wl_b), .walk_right(wr_b),
    .aaah(aa_b), .digging(dg_b), .splat(sp_b)
  );

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic bl, input logic br,
                      input logic g, input logic d, input logic [4:0] ea,
                      input string tag, input bit cb = 1'b0,
                      input logic [4:0] eb = 5'b00000);
    sb_t e;
    @(negedge clk);
    areset = rst; bump_left = bl; bump_right = br; ground = g; dig = d;
    e.tag = tag; e.exp_a = ea; e.chk_b = cb; e.exp_b = eb;
    sb_q.push_back(e);
  endtask

  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val({e.tag, "/a"}, {wl_a, wr_a, aa_a, dg_a, sp_a}, e.exp_a);
        $display("cycle %s: a=%b b=%b", e.tag, {wl_a, wr_a, aa_a, dg_a, sp_a},
                 {wl_b, wr_b, aa_b, dg_b, sp_b});
        if (e.chk_b)
          check_val({e.tag, "/b"}, {wl_b, wr_b, aa_b, dg_b, sp_b}, e.exp_b);
      end
    end
  end

  initial begin
    logic r0, r1, r2, r3;
    areset = 1'b0; bump_left = 1'b0; bump_right = 1'b0; ground = 1'b1; dig = 1'b0;

    // Reset and bump handling
    step(1, 0, 0, 1, 0, O_WL, "reset", 1'b1, O_WR);
    step(0, 1, 0, 1, 0, O_WR, "bump_l");
    step(0, 1, 1, 1, 0, O_WL, "bump_both");
    step(0, 0, 1, 1, 0, O_WL, "bump_nonfacing");

    // Fall while walking right, bumps ignored
    step(0, 1, 0, 1, 0, O_WR, "to_right");
    for (int i = 0; i < 5; i++) step(0, 1'(i % 2), 1'((i + 1) % 2), 0, 0, O_AA, "fall5");
    step(0, 0, 0, 1, 0, O_WR, "land5");
    step(0, 0, 0, 1, 0, O_WR, "walk_after_land");

    // Dig, then fall out of the hole; no resume of digging
    step(0, 0, 1, 1, 0, O_WL, "to_left");
    step(0, 1, 0, 1, 1, O_DG, "dig_start");
    for (int i = 0; i < 3; i++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      step(0, r0, r1, 1, 1'($urandom_range(0, 1)), O_DG, "dig_hold");
    end
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, O_AA, "dig_fall");
    step(0, 0, 0, 1, 1, O_WL, "dig_land");
    step(0, 0, 0, 1, 0, O_WL, "walk_after_dig");

    // Fall-length boundary: 20 cycles safe, 21 cycles fatal
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, O_AA, "fall20");
    step(0, 0, 0, 1, 0, O_WL, "land20");
    for (int i = 0; i < 21; i++) step(0, 0, 0, 0, 0, O_AA, "fall21");
    step(0, 0, 0, 1, 0, O_SP, "land21");
    for (int i = 0; i < 50; i++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1)); r3 = 1'($urandom_range(0, 1));
      step(0, r0, r1, r2, r3, O_SP, "splat_hold");
    end

    // Long fall must saturate, not wrap
    step(1, 0, 0, 1, 0, O_WL, "reset_from_splat");
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 0, O_AA, "fall300");
    step(0, 0, 0, 1, 0, O_SP, "land300");

    // Reset mid-fall clears the counter
    step(1, 0, 0, 1, 0, O_WL, "reset2");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, O_AA, "fall10");
    step(1, 1, 1, 0, 1, O_WL, "reset_midfall");
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, O_AA, "fall15");
    step(0, 0, 0, 1, 0, O_WL, "land15");

    // Variant: reset right, digging disabled
    step(1, 0, 0, 1, 0, O_WL, "var_reset", 1'b1, O_WR);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, O_DG, "var_dig", 1'b1, O_WR);
    step(0, 0, 1, 1, 1, O_DG, "var_bump_r", 1'b1, O_WL);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check_val("scoreboard_drain", 5'(sb_q.size()), 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
